// File: rtl/packet_fetch_unit.sv
// packet_fetch_unit: PC-driven packet fetch engine over a writable store, with one-shot, loop and redirect modes
module packet_fetch_unit #(
  parameter int PKT_W = 38,
  parameter int PC_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pc_update,
  input  logic [PC_W-1:0]  pc_load,
  input  logic [PC_W-1:0]  end_pc,
  input  logic             loop_en,
  input  logic             wr_en,
  input  logic [PC_W-1:0]  wr_addr,
  input  logic [PKT_W-1:0] wr_data,
  input  logic             pkt_ready,
  output logic             pkt_valid,
  output logic [PKT_W-1:0] packet_out,
  output logic [PC_W-1:0]  pc_out,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;
  state_t state;
  logic [PKT_W-1:0] mem [2**PC_W];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  // The store read lands in packet_out on the edge leaving FETCH, so a same-cycle write returns old data.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      pc_out     <= '0;
      packet_out <= '0;
      pkt_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_update) pc_out <= pc_load;
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH:
          if (pc_update) pc_out <= pc_load;
          else begin
            packet_out <= mem[pc_out];
            pkt_valid  <= 1'b1;
            state      <= PRESENT;
          end
        PRESENT:
          if (pc_update) begin
            pc_out    <= pc_load;
            pkt_valid <= 1'b0;
            state     <= FETCH;
          end else if (pkt_ready) begin
            pkt_valid <= 1'b0;
            if (pc_out != end_pc) begin
              pc_out <= pc_out + 1'b1;
              state  <= FETCH;
            end else if (loop_en) begin
              pc_out <= '0;
              state  <= FETCH;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule
